// File: rtl/clkfwd.sv
// Forwarded-clock generator: divides sys_clk by a programmable ratio D and drives
// a registered, glitch-free differential clock pair. Ratio changes land on period boundaries.
module clkfwd #(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned DIV_INIT = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             fwd_en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   output logic             div_err,
   output logic             fwd_clk_p,
   output logic             fwd_clk_n,
   output logic             fwd_active,
   output logic             edge_rise
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_cur_q, div_cur_d;
   logic [DIV_W-1:0] div_pend_q, div_pend_d;
   logic             pend_q, pend_d;
   logic             fwd_clk_p_q, fwd_clk_p_d;
   logic             fwd_clk_n_q, fwd_clk_n_d;
   logic             fwd_active_q, fwd_active_d;
   logic             edge_rise_q, edge_rise_d;
   logic             div_err_q, div_err_d;
   logic             div_ready_q, div_ready_d;

   logic             xfer;
   logic             apply;
   logic             period_end;
   logic [DIV_W-1:0] cnt_inc;

   // Next-state: waveform sequencing, ratio handshake and boundary-aligned ratio apply
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_cur_d    = div_cur_q;
      div_pend_d   = div_pend_q;
      pend_d       = pend_q;
      fwd_clk_p_d  = fwd_clk_p_q;
      fwd_active_d = fwd_active_q;
      edge_rise_d  = 1'b0;
      div_err_d    = 1'b0;
      apply        = 1'b0;
      xfer         = div_valid && div_ready_q;
      period_end   = (cnt_q == (div_cur_q - DIV_W'(1)));
      cnt_inc      = cnt_q + DIV_W'(1);

      case (state_q)
         S_IDLE: begin
            apply = pend_q;
            cnt_d = '0;
            if (fwd_en) begin
               state_d      = S_RUN;
               fwd_clk_p_d  = 1'b1;
               edge_rise_d  = 1'b1;
               fwd_active_d = 1'b1;
            end else begin
               fwd_clk_p_d  = 1'b0;
               fwd_active_d = 1'b0;
            end
         end
         S_RUN: begin
            if (period_end) begin
               apply = pend_q;
               cnt_d = '0;
               // Every legal ratio has at least one high cycle, so a new period starts high
               if (fwd_en) begin
                  fwd_clk_p_d = 1'b1;
                  edge_rise_d = 1'b1;
               end else begin
                  state_d      = S_IDLE;
                  fwd_clk_p_d  = 1'b0;
                  fwd_active_d = 1'b0;
               end
            end else begin
               cnt_d       = cnt_inc;
               fwd_clk_p_d = (cnt_inc < (div_cur_q >> 1));
            end
         end
         default: begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            fwd_clk_p_d  = 1'b0;
            fwd_active_d = 1'b0;
         end
      endcase

      if (apply) begin
         div_cur_d = div_pend_q;
         pend_d    = 1'b0;
      end

      // A transfer can only happen while nothing is pending, so it never collides with apply
      if (xfer) begin
         if (div_in < DIV_W'(2)) begin
            div_err_d = 1'b1;
         end else begin
            div_pend_d = div_in;
            pend_d     = 1'b1;
         end
      end

      fwd_clk_n_d = ~fwd_clk_p_d;
      div_ready_d = ~pend_d;
   end

   // State and output registers; both clock legs are sibling flops
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         div_cur_q    <= DIV_W'(DIV_INIT);
         div_pend_q   <= DIV_W'(DIV_INIT);
         pend_q       <= 1'b0;
         fwd_clk_p_q  <= 1'b0;
         fwd_clk_n_q  <= 1'b1;
         fwd_active_q <= 1'b0;
         edge_rise_q  <= 1'b0;
         div_err_q    <= 1'b0;
         div_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_cur_q    <= div_cur_d;
         div_pend_q   <= div_pend_d;
         pend_q       <= pend_d;
         fwd_clk_p_q  <= fwd_clk_p_d;
         fwd_clk_n_q  <= fwd_clk_n_d;
         fwd_active_q <= fwd_active_d;
         edge_rise_q  <= edge_rise_d;
         div_err_q    <= div_err_d;
         div_ready_q  <= div_ready_d;
      end
   end

   assign fwd_clk_p  = fwd_clk_p_q;
   assign fwd_clk_n  = fwd_clk_n_q;
   assign fwd_active = fwd_active_q;
   assign edge_rise  = edge_rise_q;
   assign div_err    = div_err_q;
   assign div_ready  = div_ready_q;

endmodule

// File: tb/tb_clkfwd.sv
// Directed bench for clkfwd: waveform shape per ratio, ratio handshake, enable gating and async reset.
module tb_clkfwd;

   localparam int unsigned DIV_W = 8;

   logic             sys_clk;
   logic             sys_rst_n;
   logic             fwd_en;
   logic [DIV_W-1:0] div_in;
   logic             div_valid;
   logic             div_ready;
   logic             div_err;
   logic             fwd_clk_p;
   logic             fwd_clk_n;
   logic             fwd_active;
   logic             edge_rise;

   int checks   = 0;
   int failures = 0;

   clkfwd #(.DIV_W(DIV_W), .DIV_INIT(4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .fwd_en     (fwd_en),
      .div_in     (div_in),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_err    (div_err),
      .fwd_clk_p  (fwd_clk_p),
      .fwd_clk_n  (fwd_clk_n),
      .fwd_active (fwd_active),
      .edge_rise  (edge_rise)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic p, input logic er, input logic act,
                          input logic rdy, input logic err);
      chk({tag, ".p"},   fwd_clk_p,  p);
      chk({tag, ".n"},   fwd_clk_n,  ~p);
      chk({tag, ".er"},  edge_rise,  er);
      chk({tag, ".act"}, fwd_active, act);
      chk({tag, ".rdy"}, div_ready,  rdy);
      chk({tag, ".err"}, div_err,    err);
   endtask

   task automatic step();
      @(negedge sys_clk);
   endtask

   // Walks cnt = start..d-1 of a running period: high while cnt < d/2, strobe at cnt 0
   task automatic run_tail(input string tag, input int d, input int start, input logic rdy);
      for (int k = start; k < d; k++) begin
         step();
         chk_all($sformatf("%s.d%0d.k%0d", tag, d, k), (k < d / 2), (k == 0), 1'b1, rdy, 1'b0);
      end
   endtask

   task automatic run_period(input string tag, input int d, input logic rdy);
      run_tail(tag, d, 0, rdy);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      fwd_en    = 1'b0;
      div_in    = '0;
      div_valid = 1'b0;
      step();
      step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      sys_rst_n = 1'b1;
      step();
      chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // D=4 from reset: 1100 repeating, strobe at cycles 1,5,9
      fwd_en = 1'b1;
      run_period("d4a", 4, 1'b1);
      run_period("d4b", 4, 1'b1);
      run_period("d4c", 4, 1'b1);

      // Offer 5 at cnt=1: current period completes as 1100, then 11000
      step();
      chk_all("c5.k0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("c5.k1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      div_in    = 8'd5;
      div_valid = 1'b1;
      step();
      chk_all("c5.k2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      div_valid = 1'b0;
      step();
      chk_all("c5.k3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_period("d5a", 5, 1'b1);
      run_period("d5b", 5, 1'b1);

      // Illegal ratios 1 and 0: one err pulse each, ratio unchanged
      div_in    = 8'd1;
      div_valid = 1'b1;
      step();
      chk_all("e1.k0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      div_valid = 1'b0;
      step();
      chk_all("e1.k1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      div_in    = 8'd0;
      div_valid = 1'b1;
      step();
      chk_all("e0.k2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      div_valid = 1'b0;
      step();
      chk_all("e0.k3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("e0.k4", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run_period("d5c", 5, 1'b1);

      // Offer 4 on the period-end cycle: misses this boundary, applies at the next
      div_in    = 8'd4;
      div_valid = 1'b1;
      step();
      chk_all("late.k0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      div_valid = 1'b0;
      run_tail("late", 5, 1, 1'b0);
      run_period("d4d", 4, 1'b1);

      // Enable glitch inside a period is ignored
      step();
      chk_all("eg.k0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      fwd_en = 1'b0;
      step();
      chk_all("eg.k1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("eg.k2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      fwd_en = 1'b1;
      step();
      chk_all("eg.k3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run_period("d4e", 4, 1'b1);

      // Disable for a whole period: period completes, then idle
      step();
      chk_all("dis.k0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      fwd_en = 1'b0;
      run_tail("dis", 4, 1, 1'b1);
      step();
      chk_all("dis.idle0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_all("dis.idle1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // D=3 loaded in IDLE: pend for one cycle, then 100 repeating
      div_in    = 8'd3;
      div_valid = 1'b1;
      step();
      chk_all("i3.pend", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      div_valid = 1'b0;
      step();
      chk_all("i3.appl", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      fwd_en = 1'b1;
      run_period("d3a", 3, 1'b1);
      run_period("d3b", 3, 1'b1);

      // D=255: 127 high, 128 low
      step();
      chk_all("m.k0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      div_in    = 8'd255;
      div_valid = 1'b1;
      run_tail("m", 3, 1, 1'b0);
      div_valid = 1'b0;
      run_period("d255", 255, 1'b1);

      // Pending 6 then async reset mid high phase: outputs drop at once, pending lost
      div_in    = 8'd6;
      div_valid = 1'b1;
      step();
      chk_all("r.k0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      div_valid = 1'b0;
      #1;
      sys_rst_n = 1'b0;
      #1;
      chk_all("r.async", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      sys_rst_n = 1'b1;
      run_period("post_rst_a", 4, 1'b1);
      run_period("post_rst_b", 4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clkfwd.md
# clkfwd

Clock-forwarding generator: derives a programmable, glitch-free divided clock from `sys_clk` and drives it off-chip as a registered differential pair (`fwd_clk_p`/`fwd_clk_n`), which the top level feeds to an output differential buffer. It is the transmit-side counterpart of the differential clock input path. It lets an external device receive a clock phase-locked to the on-board `sys_clk`. The divide ratio is changed through a valid/ready handshake and takes effect only on a period boundary.

## Interface
- `DIV_W`, 8: width of the divide ratio and the period counter.
- `DIV_INIT`, 4: divide ratio after reset; must be in 2..2^DIV_W-1.

- `sys_clk`  in  1  sole clock; all logic on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `fwd_en`  in  1  level request to forward the clock; sampled only in IDLE and at period end.
- `div_in`  in  DIV_W  requested divide ratio D.
- `div_valid`  in  1  `div_in` offered.
- `div_ready`  out  1  block can accept a ratio.
- `div_err`  out  1  one-cycle pulse: a ratio < 2 was offered and rejected.
- `fwd_clk_p`  out  1  forwarded clock, true leg.
- `fwd_clk_n`  out  1  forwarded clock, complement leg.
- `fwd_active`  out  1  high while in RUN.
- `edge_rise`  out  1  one-cycle strobe, high in each cycle where `fwd_clk_p` is at the first cycle of its high phase.

## Operation
- Internal registers:
  - `div_cur`, reset `DIV_INIT`.
  - `div_pend`.
  - `pend`, reset 0.
  - `cnt` (DIV_W bits), reset 0.
  - `state`, reset IDLE.
- Reset values: `fwd_clk_p`=0, `fwd_clk_n`=1, `fwd_active`=0, `edge_rise`=0, `div_err`=0, `div_ready`=1.
- Ratio handshake:
  - `div_ready` = !`pend`.
  - Transfer when `div_valid` && `div_ready`.
  - `div_in` < 2: nothing is stored, `pend` stays 0, and `div_err` pulses the next cycle.
  - Otherwise `div_pend`<=`div_in` and `pend`<=1.
- Ratio apply:
  - In IDLE, `div_cur`<=`div_pend` on the cycle after `pend` is seen, and `pend` clears.
  - In RUN, the pending ratio applies only at period end (`cnt`==`div_cur`-1), for the next period; `pend` clears that cycle.
  - A transfer in the same cycle as period end misses that boundary and applies at the following one.
- Waveform for ratio D, with H = floor(D/2):
  - `cnt` runs 0..D-1 and wraps.
  - `fwd_clk_p` is high for `cnt` in 0..H-1 and low for `cnt` in H..D-1. This gives H high cycles and D-H low cycles per period.
  - `fwd_clk_n` is the exact complement every cycle.
- States:
  - IDLE: `fwd_clk_p`=0, `cnt`=0. If `fwd_en`=1, go to RUN with `cnt`=0, `fwd_clk_p`=1, `edge_rise`=1 in the next cycle.
  - RUN: `cnt` increments. At period end, if `fwd_en`=1 then `cnt`<=0 and a new period starts; else go to IDLE.
- `fwd_en` changes inside a period are ignored, so no runt pulses occur on enable or disable.
- A ratio change never shortens or stretches the current period.
- Reset mid-operation forces the reset values immediately, without a clock, and discards any pending ratio.

## Timing
- All outputs come directly from flops. `fwd_clk_p` and `fwd_clk_n` are separate flops clocked together (matched skew).
- Latency from `fwd_en` high in IDLE to the first `fwd_clk_p` rise is 1 cycle.
- Latency from disable to the output stopping: the remainder of the current period; `fwd_active` drops together with the return to IDLE.
- `div_ready` returns high the cycle after the pending ratio applies.
- `div_err` pulses one cycle after the rejected transfer.
- `div_cur` maximum is 2^DIV_W-1; `cnt` never exceeds `div_cur`-1.

## Test plan
- Reset with DIV_INIT=4, then `fwd_en`=1 at cycle 0 -> `fwd_clk_p` reads 1,1,0,0 repeating from cycle 1, `fwd_clk_n` the complement, `edge_rise` at cycles 1,5,9.
- RUN at D=4, offer `div_in`=5 at `cnt`=1 -> `div_ready` low, the current period completes as 1100, then the pattern is 11000 repeating; `div_ready` goes high the cycle after the boundary.
- Offer `div_in`=1, then `div_in`=0 -> `div_err` pulses once per offer, ratio unchanged, waveform undisturbed, `div_ready` stays 1.
- D=4, drop `fwd_en` at `cnt`=0 and re-raise it at `cnt`=2 -> no effect. Drop it again for a whole period -> the period completes, then `fwd_clk_p`=0/`fwd_clk_n`=1 and `fwd_active`=0.
- D=3 -> pattern 100. `div_in`=255 with DIV_W=8 -> 127 high and 128 low cycles, no counter overflow.
- Assert `sys_rst_n`=0 mid high phase, between clock edges -> `fwd_clk_p`=0 and `fwd_clk_n`=1 immediately. After release, D=DIV_INIT and the earlier pending ratio is lost.
